// File: rtl/receiver_mpi_fifo.sv
// Receiving endpoint of a metro-mpi link: credit (valid/yummy) input, DEPTH-entry FIFO, valid/ready output.
// Optional word counters are enabled by defining RECEIVER_MPI_FIFO_STATS_EN.
module receiver_mpi_fifo #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 4,
  parameter int RX_RANK = 3,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       rank_i,
  input  logic [31:0]       origin_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic              yummy_o,
  output logic [CNT_W-1:0]  occupancy_o,
  output logic              overflow_o,
  output logic [31:0]       rx_count_o,
  output logic [31:0]       tx_count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  occ;
  logic              overflow_q;
  logic              yummy_q;
  logic              active;
  logic              full;
  logic              push;
  logic              pop;

  // Source rank is carried for debug visibility only.
  logic unused_origin;
  assign unused_origin = ^origin_i;

  assign active = (rank_i == 32'(RX_RANK));
  assign full   = (occ == CNT_W'(DEPTH));
  assign push   = valid_i && active && !full;
  assign pop    = data_valid_o && data_ready_i;

  assign data_o       = mem[rd_ptr];
  assign data_valid_o = active && (occ != '0);
  assign occupancy_o  = occ;
  assign overflow_o   = overflow_q;
  assign yummy_o      = yummy_q && active;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      overflow_q <= 1'b0;
      yummy_q    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      occ <= occ + CNT_W'(push) - CNT_W'(pop);
      // Full is judged before any same-cycle pop: the sender cannot own that slot yet.
      if (valid_i && active && full) begin
        overflow_q <= 1'b1;
      end
      // While inactive a credit owed from the last active cycle is held, not lost.
      if (active) begin
        yummy_q <= pop;
      end
    end
  end

`ifdef RECEIVER_MPI_FIFO_STATS_EN
  logic [31:0] rx_cnt;
  logic [31:0] tx_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_cnt <= '0;
      tx_cnt <= '0;
    end else begin
      if (push) rx_cnt <= rx_cnt + 32'd1;
      if (pop)  tx_cnt <= tx_cnt + 32'd1;
    end
  end

  assign rx_count_o = rx_cnt;
  assign tx_count_o = tx_cnt;
`else
  assign rx_count_o = '0;
  assign tx_count_o = '0;
`endif

endmodule

// File: tb/tb_receiver_mpi_fifo.sv
// Directed self-checking bench for receiver_mpi_fifo at default parameters.
module tb_receiver_mpi_fifo;

`ifdef RECEIVER_MPI_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] rank_i;
  logic [31:0] origin_i;
  logic        valid_i;
  logic [63:0] data_i;
  logic [63:0] data_o;
  logic        data_valid_o;
  logic        data_ready_i;
  logic        yummy_o;
  logic [2:0]  occupancy_o;
  logic        overflow_o;
  logic [31:0] rx_count_o;
  logic [31:0] tx_count_o;

  int n_checks = 0;
  int n_errors = 0;
  int yummies;

  receiver_mpi_fifo dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rank_i       (rank_i),
    .origin_i     (origin_i),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .yummy_o      (yummy_o),
    .occupancy_o  (occupancy_o),
    .overflow_o   (overflow_o),
    .rx_count_o   (rx_count_o),
    .tx_count_o   (tx_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i        = 1'b1;
    rank_i       = 32'd3;
    origin_i     = 32'd7;
    valid_i      = 1'b0;
    data_i       = '0;
    data_ready_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;

    chk("rst_dvalid", 64'(data_valid_o), 64'd0);
    chk("rst_yummy",  64'(yummy_o),      64'd0);
    chk("rst_occ",    64'(occupancy_o),  64'd0);
    chk("rst_ovf",    64'(overflow_o),   64'd0);
    chk("rst_data",   data_o,            64'd0);
    chk("rst_rx",     64'(rx_count_o),   64'd0);
    chk("rst_tx",     64'(tx_count_o),   64'd0);

    // Fill with ready low
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1;
      data_i  = 64'hA1 + 64'(i);
      step();
      chk("fill_yummy", 64'(yummy_o), 64'd0);
      chk("fill_occ",   64'(occupancy_o), 64'(i + 1));
    end
    valid_i = 1'b0;
    step();
    chk("full_occ",    64'(occupancy_o),  64'd4);
    chk("full_head",   data_o,            64'hA1);
    chk("full_dvalid", 64'(data_valid_o), 64'd1);
    chk("full_yummy",  64'(yummy_o),      64'd0);

    // Drain in order, one yummy per pop one cycle later
    data_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", data_o, 64'hA1 + 64'(i));
      step();
      chk("drain_yummy", 64'(yummy_o), 64'd1);
      chk("drain_occ",   64'(occupancy_o), 64'(3 - i));
    end
    data_ready_i = 1'b0;
    step();
    chk("drain_yummy_end", 64'(yummy_o), 64'd0);
    chk("drain_dvalid",    64'(data_valid_o), 64'd0);
    chk("drain_tx", 64'(tx_count_o), STATS ? 64'd4 : 64'd0);

    // Overflow with simultaneous pop
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1;
      data_i  = 64'hB1 + 64'(i);
      step();
    end
    chk("ovf_pre_occ", 64'(occupancy_o), 64'd4);
    chk("ovf_pre_rx",  64'(rx_count_o), STATS ? 64'd8 : 64'd0);
    valid_i      = 1'b1;
    data_i       = 64'hFF;
    data_ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("ovf_flag",  64'(overflow_o),  64'd1);
    chk("ovf_occ",   64'(occupancy_o), 64'd3);
    chk("ovf_yummy", 64'(yummy_o),     64'd1);
    chk("ovf_rx",    64'(rx_count_o),  STATS ? 64'd8 : 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("ovf_drain", data_o, 64'hB2 + 64'(i));
      step();
    end
    data_ready_i = 1'b0;
    step();
    chk("ovf_empty",  64'(occupancy_o), 64'd0);
    chk("ovf_sticky", 64'(overflow_o),  64'd1);

    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("ovf_cleared", 64'(overflow_o), 64'd0);
    chk("rst2_rx", 64'(rx_count_o), 64'd0);

    // Steady stream across pointer wraps
    yummies      = 0;
    valid_i      = 1'b1;
    data_i       = 64'd0;
    data_ready_i = 1'b1;
    step();
    chk("stream_occ0", 64'(occupancy_o), 64'd1);
    for (int k = 1; k < 20; k++) begin
      data_i = 64'(k);
      chk("stream_data", data_o, 64'(k - 1));
      step();
      if (yummy_o) yummies++;
      chk("stream_occ", 64'(occupancy_o), 64'd1);
    end
    valid_i = 1'b0;
    chk("stream_last", data_o, 64'd19);
    step();
    if (yummy_o) yummies++;
    data_ready_i = 1'b0;
    step();
    if (yummy_o) yummies++;
    chk("stream_yummies", 64'(yummies), 64'd20);
    chk("stream_occ_end", 64'(occupancy_o), 64'd0);
    chk("stream_rx", 64'(rx_count_o), STATS ? 64'd20 : 64'd0);
    chk("stream_tx", 64'(tx_count_o), STATS ? 64'd20 : 64'd0);

    // Inactive rank ignores traffic
    rank_i       = 32'd2;
    valid_i      = 1'b1;
    data_i       = 64'h55;
    data_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("inact_dvalid", 64'(data_valid_o), 64'd0);
      chk("inact_occ",    64'(occupancy_o),  64'd0);
      chk("inact_ovf",    64'(overflow_o),   64'd0);
    end
    rank_i  = 32'd3;
    valid_i = 1'b0;
    step();
    chk("inact_after_occ", 64'(occupancy_o), 64'd0);
    chk("inact_after_rx",  64'(rx_count_o), STATS ? 64'd20 : 64'd0);

    // Reset coincident with a pop
    data_ready_i = 1'b0;
    valid_i      = 1'b1;
    data_i       = 64'hC1;
    step();
    data_i = 64'hC2;
    step();
    valid_i = 1'b0;
    chk("rp_occ_pre", 64'(occupancy_o), 64'd2);
    chk("rp_head",    data_o, 64'hC1);
    data_ready_i = 1'b1;
    rst_i        = 1'b1;
    step();
    rst_i        = 1'b0;
    data_ready_i = 1'b0;
    chk("rp_occ",    64'(occupancy_o),  64'd0);
    chk("rp_dvalid", 64'(data_valid_o), 64'd0);
    chk("rp_yummy0", 64'(yummy_o),      64'd0);
    chk("rp_data",   data_o,            64'd0);
    step();
    chk("rp_yummy1", 64'(yummy_o),    64'd0);
    chk("rp_rx",     64'(rx_count_o), 64'd0);
    chk("rp_tx",     64'(tx_count_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/receiver_mpi_fifo.md
# receiver_mpi_fifo

Parametrised successor to the single-entry MPI credit receiver. It accepts words from an MPI link using a valid/yummy credit protocol and stores them in a DEPTH-entry FIFO. It delivers them downstream on a valid/ready interface and returns one yummy credit per word consumed. It sits at the receiving endpoint of a metro-mpi link, between the DPI/MPI transport shim and the local tile logic.

## Interface
- DATA_W, default 64: link and buffer word width.
- DEPTH, default 4: FIFO entries. Power of two, ≥2. Also the sender's initial credit count.
- RX_RANK, default 3: MPI rank on which this receiver is active.
- CNT_W, derived as $clog2(DEPTH+1): width of the occupancy counter.
- clk_i  input  1  clock.
- rst_i  input  1  reset, synchronous, active-high.
- rank_i  input  32 (int)  rank of the hosting process.
- origin_i  input  32 (int)  source rank. Informational only, no functional effect.
- valid_i  input  1  link word valid; one word per cycle.
- data_i  input  DATA_W  link word.
- data_o  output  DATA_W  FIFO head word.
- data_valid_o  output  1  head word valid.
- data_ready_i  input  1  downstream accepts head.
- yummy_o  output  1  one-cycle credit return pulse.
- occupancy_o  output  CNT_W  current entries stored.
- overflow_o  output  1  sticky protocol-violation flag.
- rx_count_o  output  32  words accepted (see Configuration).
- tx_count_o  output  32  words delivered (see Configuration).

## Operation
- Active when rank_i == RX_RANK. When inactive:
  - valid_i is ignored: no write, no error.
  - data_valid_o=0, so no pops occur.
  - yummy_o=0.
  - State is held.
- Push: valid_i && active && occupancy < DEPTH. data_i is written at wr_ptr, wr_ptr increments modulo DEPTH.
- Overflow: valid_i && active && occupancy == DEPTH.
  - The word is dropped and overflow_o sets, staying set until reset.
  - This applies even if a pop happens in the same cycle. The sender cannot legally hold a credit for that slot until the yummy has been issued.
- Pop: data_valid_o && data_ready_i. rd_ptr increments modulo DEPTH.
- data_o = mem[rd_ptr]; data_valid_o = active && occupancy != 0.
- data_o is don't-care when data_valid_o=0, but must be stable while data_valid_o=1 and data_ready_i=0.
- Occupancy update: occupancy_next = occupancy + push − pop. A simultaneous push and pop leaves it unchanged. It never exceeds DEPTH and never goes below 0.
- Credit: each pop causes exactly one yummy_o pulse. Total yummies issued never exceed total pops.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty is decided from occupancy only, never from pointer equality.

## Timing
- Reset values:
  - data_valid_o=0, yummy_o=0, occupancy_o=0, overflow_o=0, rx_count_o=0, tx_count_o=0.
  - Pointers are 0.
  - data_o=0: memory is cleared on reset.
- Push-to-output latency is 1 cycle. A word pushed at edge t is visible on data_o/data_valid_o after edge t. There is no same-cycle bypass.
- yummy_o is registered. A pop in cycle t gives yummy_o=1 in cycle t+1 only. Back-to-back pops give back-to-back yummy pulses.
- occupancy_o and overflow_o are registered and reflect the state after the last edge.
- Reset asserted mid-operation takes effect at the next edge: all stored words are discarded and no yummy is issued for them. The sender must also reset its credits to DEPTH.
- A pending yummy (pop in the cycle that reset is sampled) is cancelled.

## Configuration
- RECEIVER_MPI_FIFO_STATS_EN defined:
  - rx_count_o increments on every push; tx_count_o increments on every pop.
  - Both are 32-bit, wrap modulo 2^32, and are cleared by rst_i.
  - Overflowed words are not counted.
- Not defined: rx_count_o and tx_count_o are tied to 0 and no counter flops exist. Ports remain present, so instantiations are unchanged.

## Test plan
- Defaults (DEPTH=4, rank_i=3). Push 0xA1..0xA4 on 4 consecutive cycles with data_ready_i=0:
  - occupancy_o=4, data_o=0xA1, yummy_o never pulses.
  - Then hold data_ready_i=1: outputs 0xA1..0xA4 in order, 4 yummy pulses each 1 cycle after its pop, occupancy_o back to 0.
- With FIFO full, push 0xFF in the same cycle as a pop:
  - 0xFF is dropped and overflow_o=1 and stays 1.
  - occupancy_o=3 after the edge, rx_count_o is unchanged (STATS_EN).
- Steady stream: push and pop every cycle for 20 cycles with ramp data 0..19:
  - occupancy_o stays 1 and ordering is preserved across pointer wraps.
  - 20 yummies total; rx_count_o=tx_count_o=20 with STATS_EN, both 0 without.
- rank_i=2, valid_i=1 for 5 cycles: no writes, data_valid_o=0, overflow_o=0, occupancy_o=0.
- Push 2 words, then pop one while rst_i=1 in the same cycle:
  - Next cycle occupancy_o=0, data_valid_o=0, and yummy_o=0 on the following cycle.
  - Counters are 0 with STATS_EN.
